// File: rtl/dmem_mmio_pkg.sv
// Memory-mapped I/O address map shared by the data memory, the CPU and the LED
// display block, plus small helpers used by the data memory decode.
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_LED_ADDR  = 32'h0000_0400;
    localparam logic [31:0] MMIO_SEL_ADDR  = 32'h0000_0C00;
    localparam logic [31:0] MMIO_LVL_ADDR  = 32'h0000_1008;
    localparam logic [31:0] MMIO_EDGE_ADDR = 32'h0000_1010;
    localparam logic [31:0] MMIO_CYC_ADDR  = 32'h0000_1014;

    typedef enum logic [2:0] {
        RD_RAM,
        RD_LED,
        RD_SEL,
        RD_LVL,
        RD_EDGE,
        RD_CYC,
        RD_NONE
    } rd_src_e;

    // Word-granular match: the two byte-offset bits never take part in decode.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/btn_capture.sv
// Button synchronizer and sticky rising-edge capture with write-1-to-clear.
// A level change reaches the edge bit three clock edges after it is launched.
module btn_capture #(
    parameter int NBTN = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn,
    input  logic [NBTN-1:0] clr,
    output logic [NBTN-1:0] level,
    output logic [NBTN-1:0] edges
);

    logic [NBTN-1:0] sync1_reg;
    logic [NBTN-1:0] sync2_reg;
    logic [NBTN-1:0] hist_reg;
    logic [NBTN-1:0] edges_reg;
    logic [NBTN-1:0] edges_next;

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_bit
            logic rise;
            assign rise = sync2_reg[gi] & ~hist_reg[gi];

            // A fresh rising edge beats a simultaneous clear so no press is lost.
            assign edges_next[gi] = (edges_reg[gi] & ~clr[gi]) | rise;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                    hist_reg[gi]  <= 1'b0;
                    edges_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= btn[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                    hist_reg[gi]  <= sync2_reg[gi];
                    edges_reg[gi] <= edges_next[gi];
                end
            end
        end
    endgenerate

    assign level = sync2_reg;
    assign edges = edges_reg;

endmodule

// File: rtl/dmem_mmio.sv
// Data memory with byte-lane writes and combinational read, overlaid with MMIO
// registers: LED value/select, button level/edge capture and a cycle counter.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          DEPTH     = 1024,
    parameter int          NBTN      = 2,
    parameter logic [31:0] LED_ADDR  = MMIO_LED_ADDR,
    parameter logic [31:0] SEL_ADDR  = MMIO_SEL_ADDR,
    parameter logic [31:0] LVL_ADDR  = MMIO_LVL_ADDR,
    parameter logic [31:0] EDGE_ADDR = MMIO_EDGE_ADDR,
    parameter logic [31:0] CYC_ADDR  = MMIO_CYC_ADDR,
    parameter string       INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               memwrite,
    input  logic [WIDTH/8-1:0] be,
    input  logic [31:0]        adr,
    input  logic [WIDTH-1:0]   writedata,
    input  logic [NBTN-1:0]    btn,
    output logic [WIDTH-1:0]   memdata,
    output logic [31:0]        led_data,
    output logic [31:0]        led_sel
);

    localparam int AW     = $clog2(DEPTH);
    localparam int NBYTES = WIDTH / 8;

    logic [WIDTH-1:0] ram_mem [DEPTH];

    logic          hit_led;
    logic          hit_sel;
    logic          hit_lvl;
    logic          hit_edge;
    logic          hit_cyc;
    logic          hit_mmio;
    logic          in_range;
    logic          ram_we;
    logic [AW-1:0] word_idx;
    rd_src_e       rd_src;

    assign hit_led  = word_match(adr, LED_ADDR);
    assign hit_sel  = word_match(adr, SEL_ADDR);
    assign hit_lvl  = word_match(adr, LVL_ADDR);
    assign hit_edge = word_match(adr, EDGE_ADDR);
    assign hit_cyc  = word_match(adr, CYC_ADDR);
    assign hit_mmio = hit_led | hit_sel | hit_lvl | hit_edge | hit_cyc;

    // Addresses past the RAM must not alias back onto low words.
    assign in_range = (adr[31:AW+2] == '0);
    assign word_idx = adr[AW+1:2];
    assign ram_we   = memwrite & ~reset & ~hit_mmio & in_range;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) begin
                    ram_mem[word_idx][i*8 +: 8] <= writedata[i*8 +: 8];
                end
            end
        end
    end

    logic [31:0]      led_data_reg;
    logic [31:0]      led_sel_reg;
    logic [WIDTH-1:0] cyc_reg;
    logic [WIDTH-1:0] cyc_next;

    assign cyc_next = (memwrite && hit_cyc) ? writedata : cyc_reg + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_data_reg <= '0;
            led_sel_reg  <= '0;
            cyc_reg      <= '0;
        end else begin
            if (memwrite && hit_led) begin
                led_data_reg <= 32'(writedata);
            end
            if (memwrite && hit_sel) begin
                led_sel_reg <= 32'(writedata);
            end
            cyc_reg <= cyc_next;
        end
    end

    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_edges;
    logic [NBTN-1:0] btn_clr;

    assign btn_clr = (memwrite && hit_edge) ? writedata[NBTN-1:0] : '0;

    btn_capture #(
        .NBTN (NBTN)
    ) u_btn_capture (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .clr   (btn_clr),
        .level (btn_level),
        .edges (btn_edges)
    );

    always_comb begin
        rd_src = RD_NONE;
        if (hit_led) begin
            rd_src = RD_LED;
        end else if (hit_sel) begin
            rd_src = RD_SEL;
        end else if (hit_lvl) begin
            rd_src = RD_LVL;
        end else if (hit_edge) begin
            rd_src = RD_EDGE;
        end else if (hit_cyc) begin
            rd_src = RD_CYC;
        end else if (in_range) begin
            rd_src = RD_RAM;
        end
    end

    always_comb begin
        memdata = '0;
        case (rd_src)
            RD_RAM:  memdata = ram_mem[word_idx];
            RD_LED:  memdata = WIDTH'(led_data_reg);
            RD_SEL:  memdata = WIDTH'(led_sel_reg);
            RD_LVL:  memdata = WIDTH'(btn_level);
            RD_EDGE: memdata = WIDTH'(btn_edges);
            RD_CYC:  memdata = cyc_reg;
            default: memdata = '0;
        endcase
    end

    assign led_data = led_data_reg;
    assign led_sel  = led_sel_reg;

    logic unused_adr_lsbs;
    assign unused_adr_lsbs = ^adr[1:0];

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: byte lanes, MMIO decode, button edge capture,
// cycle counter wrap, out-of-range access and mid-run reset.
module tb_dmem_mmio;

    localparam logic [31:0] LED_A  = 32'h0000_0400;
    localparam logic [31:0] SEL_A  = 32'h0000_0C00;
    localparam logic [31:0] LVL_A  = 32'h0000_1008;
    localparam logic [31:0] EDGE_A = 32'h0000_1010;
    localparam logic [31:0] CYC_A  = 32'h0000_1014;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [3:0]  be;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic [1:0]  btn;
    logic [31:0] memdata;
    logic [31:0] led_data;
    logic [31:0] led_sel;

    int checks_cnt;
    int errors_cnt;

    logic [31:0] ram100_snap;

    dmem_mmio dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .be        (be),
        .adr       (adr),
        .writedata (writedata),
        .btn       (btn),
        .memdata   (memdata),
        .led_data  (led_data),
        .led_sel   (led_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        adr       = a;
        writedata = d;
        be        = b;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        be       = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        adr = a;
        #1;
        chk(tag, memdata, exp);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        reset      = 1'b1;
        memwrite   = 1'b0;
        be         = 4'h0;
        adr        = 32'h0;
        writedata  = 32'h0;
        btn        = 2'b00;

        // Reset state
        #2;
        chk("rst_led_data", led_data, 32'h0);
        chk("rst_led_sel", led_sel, 32'h0);
        rd("rst_edge", EDGE_A, 32'h0);
        rd("rst_cyc", CYC_A, 32'h0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // Byte-lane writes
        wr(32'h8, 32'h1122_3344, 4'hF);
        wr(32'h8, 32'hAABB_CCDD, 4'b0010);
        rd("be_lane1", 32'h8, 32'h1122_CC44);
        wr(32'h0, 32'hDEAD_BEEF, 4'hF);
        wr(32'h0, 32'h0000_0000, 4'h0);
        rd("be_zero_noop", 32'h0, 32'hDEAD_BEEF);
        rd("adr_lsb_ignored", 32'h3, 32'hDEAD_BEEF);

        // LED/SEL registers shadow RAM words without touching them
        ram100_snap = dut.ram_mem[256];
        wr(LED_A, 32'h0000_1234, 4'h0);
        wr(SEL_A, 32'h0000_000F, 4'h1);
        chk("led_data_port", led_data, 32'h0000_1234);
        chk("led_sel_port", led_sel, 32'h0000_000F);
        rd("led_readback", LED_A, 32'h0000_1234);
        rd("sel_readback", SEL_A, 32'h0000_000F);
        chk("ram100_kept", dut.ram_mem[256], ram100_snap);
        chk("ram100_not_led", 32'(dut.ram_mem[256] == 32'h0000_1234), 32'h0);

        // Button edge: launched just after edge N, visible from edge N+3
        @(posedge clk);
        #1;
        btn = 2'b10;
        adr = EDGE_A;
        @(posedge clk);
        #1 chk("edge_n1", memdata, 32'h0);
        @(posedge clk);
        #1 chk("edge_n2", memdata, 32'h0);
        rd("lvl_n2", LVL_A, 32'h2);
        adr = EDGE_A;
        @(posedge clk);
        #1 chk("edge_n3", memdata, 32'h2);
        wr(LVL_A, 32'hFFFF_FFFF, 4'hF);
        rd("lvl_write_ignored", LVL_A, 32'h2);
        wr(EDGE_A, 32'h1, 4'hF);
        rd("edge_clr_other_bit", EDGE_A, 32'h2);
        wr(EDGE_A, 32'h2, 4'hF);
        rd("edge_w1c", EDGE_A, 32'h0);

        // Clear coincident with a new rising edge: the edge wins
        btn = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        btn = 2'b10;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        adr = EDGE_A;
        #1 chk("edge_before_coinc", memdata, 32'h0);
        writedata = 32'h2;
        be        = 4'hF;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        rd("edge_coincident", EDGE_A, 32'h2);

        // Cycle counter load and wrap
        wr(CYC_A, 32'hFFFF_FFFE, 4'h0);
        rd("cyc_loaded", CYC_A, 32'hFFFF_FFFE);
        @(posedge clk);
        #1 chk("cyc_all_ones", memdata, 32'hFFFF_FFFF);
        @(posedge clk);
        #1 chk("cyc_wrap", memdata, 32'h0);
        @(posedge clk);
        #1 chk("cyc_after_wrap", memdata, 32'h1);

        // Out of range access
        wr(32'h0000_1000, 32'h0000_0055, 4'hF);
        rd("oob_read", 32'h0000_1000, 32'h0);
        rd("oob_no_alias_w0", 32'h0, 32'hDEAD_BEEF);
        rd("oob_word2_kept", 32'h8, 32'h1122_CC44);

        // Reset mid-run: registers clear, RAM stays, writes dropped
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_led", led_data, 32'h0);
        chk("mid_rst_sel", led_sel, 32'h0);
        rd("mid_rst_edge", EDGE_A, 32'h0);
        rd("mid_rst_cyc", CYC_A, 32'h0);
        @(negedge clk);
        adr       = 32'h0;
        writedata = 32'h1234_5678;
        be        = 4'hF;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        be       = 4'h0;
        #2 reset = 1'b0;
        rd("rst_ram_kept", 32'h0, 32'hDEAD_BEEF);
        rd("rst_ram_word2", 32'h8, 32'h1122_CC44);
        rd("cyc_post_rst", CYC_A, 32'h0);
        @(posedge clk);
        #1 chk("cyc_first_edge", memdata, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 1024, RAM depth in words; must be a power of 2.
REQ-003 SHALL have parameter NBTN, default 2, number of button inputs, 1..WIDTH.
REQ-004 SHALL have parameter LED_ADDR/SEL_ADDR/LVL_ADDR/EDGE_ADDR/CYC_ADDR, defaults 32'h400/32'hC00/32'h1008/32'h1010/32'h1014, MMIO byte addresses.
REQ-005 SHALL have parameter INIT_FILE, default "", binary $readmemb image; no load when empty.
REQ-006 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port memwrite, input, 1, write strobe.
REQ-009 SHALL have port be, input, WIDTH/8, byte-lane write enables.
REQ-010 SHALL have port adr, input, 32, byte address; adr[1:0] ignored.
REQ-011 SHALL have port writedata, input, WIDTH, write data.
REQ-012 SHALL have port btn, input, NBTN, raw asynchronous button levels.
REQ-013 SHALL have port memdata, output, WIDTH, combinational read data.
REQ-014 SHALL have port led_data, output, 32, LED value register for the led display block.
REQ-015 SHALL have port led_sel, output, 32, digit-select register for the led display block.

Function
REQ-016 SHALL decode MMIO addresses with priority over RAM; an MMIO hit never touches RAM.
REQ-017 SHALL index RAM by adr>>2 for both read and write (consistent word addressing).
REQ-018 SHALL ignore writes and read 0 for non-MMIO addresses with (adr>>2) >= DEPTH.
REQ-019 SHALL write RAM lanes with be[i]=1 only, on the clk edge where memwrite=1; be=0 is a no-op.
REQ-020 SHALL read memdata combinationally in the same cycle; a read of the address being written returns the old value until the edge.
REQ-021 SHALL write led_data/led_sel whole-word on memwrite to LED_ADDR/SEL_ADDR, ignoring be; readback returns the register.
REQ-022 SHALL pass btn through a 2-flop synchronizer per bit; LVL_ADDR reads the synchronized level zero-extended; writes to it are ignored.
REQ-023 SHALL set sticky edge bit i on a synchronized 0->1 transition of btn[i]; EDGE_ADDR reads the bits zero-extended.
REQ-024 SHALL clear edge bit i when EDGE_ADDR is written with writedata[i]=1 (write-1-to-clear); a same-cycle new rising edge wins (bit stays 1).
REQ-025 SHALL run a WIDTH-bit free-running cycle counter, +1 per clock, wrapping all-ones->0; CYC_ADDR reads it; a write loads writedata.
REQ-026 SHALL produce a rising-edge-to-edge-bit latency of exactly 3 clocks (2 sync + 1 detect).

Reset
REQ-027 SHALL, while reset=1, clear led_data, led_sel, synchronizers, edge-detect history, edge bits and counter to 0 asynchronously.
REQ-028 SHALL leave RAM contents unaffected by reset; writes during reset are dropped.
REQ-029 SHALL start counting from 0 on the first clk edge after reset deassertion.

Structure
REQ-030 SHALL take MMIO address defaults from a shared package/include (mmio_map), shared with the CPU and led block.
REQ-031 SHALL implement button sync + edge capture as sub-module btn_capture (NBTN-wide), instantiated once.

Verification
REQ-032 SHALL cover: be=4'b0010, writedata=32'hAABBCCDD to adr 0x8 over 0x11223344 -> read 0x1122CC44.
REQ-033 SHALL cover: write 0x1234 to LED_ADDR, 0x0F to SEL_ADDR -> led_data=0x1234, led_sel=0x0F, RAM word 0x100 unchanged.
REQ-034 SHALL cover: btn[1] 0->1 at edge N -> EDGE reads 0x2 from edge N+3; write 0x2 -> 0x0; write 0x2 coincident with new edge -> stays 0x2.
REQ-035 SHALL cover: write 32'hFFFFFFFE to CYC_ADDR -> reads FFFFFFFF, then 0 on following cycles.
REQ-036 SHALL cover: adr=DEPTH*4 write 0x55 -> read 0, no RAM word altered; reset mid-run -> LED/SEL/EDGE/CYC=0, RAM retained.
